// File: rtl/arb_requester.sv
// Client-side agent for one request/grant lane of a fixed-priority arbiter.
// Buffers client words, requests the bus while holding data, and caps each grant tenure.
module arb_requester #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned MaxBurst  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    output logic                 request,
    input  logic                 grant,
    output logic                 bus_valid,
    output logic [DataWidth-1:0] bus_data,
    output logic                 tenure_done
);

    localparam int unsigned PtrW  = $clog2(FifoDepth);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BeatW = $clog2(MaxBurst + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_request;
    logic                 w_request_nxt;
    logic [BeatW-1:0]     r_beat_cnt;
    logic [BeatW-1:0]     w_beat_cnt_nxt;
    logic [CntW-1:0]      r_count;
    logic [CntW-1:0]      w_count_nxt;
    logic [PtrW-1:0]      r_wr_ptr;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [DataWidth-1:0] r_mem [FifoDepth];

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_last_beat;
    logic w_tenure_end;

    // FIFO handshake and beat qualification; request is registered so there is no loop through grant
    always_comb begin
        w_full       = (r_count == CntW'(FifoDepth));
        w_push       = in_valid && !w_full;
        w_pop        = r_request && grant && (r_count != '0);
        w_count_nxt  = r_count + CntW'(w_push) - CntW'(w_pop);
        w_last_beat  = ((r_beat_cnt + BeatW'(1)) == BeatW'(MaxBurst));
        w_tenure_end = w_pop && (w_last_beat || (w_count_nxt == '0));
    end

    assign in_ready    = !w_full;
    assign request     = r_request;
    assign bus_valid   = w_pop;
    assign bus_data    = r_mem[r_rd_ptr];
    assign tenure_done = w_tenure_end;

    // Next-state logic: a tenure ends on the capped beat or when the FIFO drains
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_tenure_end) begin
                    w_state_nxt    = S_COOL;
                    w_beat_cnt_nxt = '0;
                end else if (w_pop) begin
                    w_beat_cnt_nxt = r_beat_cnt + BeatW'(1);
                end
            end
            S_COOL: begin
                w_state_nxt = (r_count != '0) ? S_BUSY : S_IDLE;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_beat_cnt_nxt = '0;
            end
        endcase
        w_request_nxt = (w_state_nxt == S_BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_request  <= 1'b0;
            r_beat_cnt <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_request  <= w_request_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_count    <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

    // Storage needs no reset: contents are only observed behind a valid count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: queue-based reference model plus directed literal checks.
module tb_arb_requester;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int MAXB  = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          request;
    logic          grant;
    logic          bus_valid;
    logic [DW-1:0] bus_data;
    logic          tenure_done;

    int n_cmp = 0;
    int n_err = 0;

    arb_requester #(
        .DataWidth(DW),
        .FifoDepth(DEPTH),
        .MaxBurst (MAXB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .request    (request),
        .grant      (grant),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .tenure_done(tenure_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: queue of words, a request flag and a beat count for the current tenure
    logic [DW-1:0] mq[$];
    bit            m_req;
    int            m_beats;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_req   = 1'b0;
            m_beats = 0;
        end else begin
            bit e_ready, e_push, e_bv, e_td;
            int occ;
            occ     = mq.size();
            e_ready = (occ < DEPTH);
            e_push  = in_valid && e_ready;
            e_bv    = m_req && grant && (occ != 0);
            e_td    = e_bv && ((m_beats + 1 == MAXB) ||
                               (occ - (e_bv ? 1 : 0) + (e_push ? 1 : 0) == 0));
            chk("in_ready",    32'(in_ready),    32'(e_ready));
            chk("request",     32'(request),     32'(m_req));
            chk("bus_valid",   32'(bus_valid),   32'(e_bv));
            chk("tenure_done", 32'(tenure_done), 32'(e_td));
            if (e_bv) chk("bus_data", 32'(bus_data), 32'(mq[0]));
            if (e_bv) void'(mq.pop_front());
            if (e_push) mq.push_back(in_data);
            if (m_req) begin
                if (e_td) begin
                    m_req   = 1'b0;
                    m_beats = 0;
                end else if (e_bv) begin
                    m_beats++;
                end
            end else begin
                m_req = (occ != 0);
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        grant    = 1'b1;
        repeat (12) adv();
    endtask

    initial begin
        logic [DW-1:0] word;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        grant    = 1'b0;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_request",     32'(request),     32'd0);
        chk("rst_in_ready",    32'(in_ready),    32'd1);
        chk("rst_bus_valid",   32'(bus_valid),   32'd0);
        chk("rst_tenure_done", 32'(tenure_done), 32'd0);
        adv();
        rst = 1'b0;

        // Single word with grant tied high
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0);
            in_data  = 8'hA5;
            grant    = 1'b1;
            mid();
            if (c < 2) chk("single_req_low", 32'(request), 32'd0);
            if (c == 2) begin
                chk("single_req",  32'(request),     32'd1);
                chk("single_bv",   32'(bus_valid),   32'd1);
                chk("single_data", 32'(bus_data),    32'hA5);
                chk("single_td",   32'(tenure_done), 32'd1);
            end
            if (c == 3) chk("single_req_drop", 32'(request), 32'd0);
            adv();
        end
        drain();

        // Burst cap: six words, four beats, one cooldown cycle, two beats
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 6);
            in_data  = 8'(c + 1);
            grant    = 1'b1;
            mid();
            if (c == 2) chk("burst_first", 32'(bus_data), 32'h01);
            if (c == 5) begin
                chk("burst_cap_data", 32'(bus_data),    32'h04);
                chk("burst_cap_td",   32'(tenure_done), 32'd1);
            end
            if (c == 6) begin
                chk("burst_cool_req", 32'(request),   32'd0);
                chk("burst_cool_bv",  32'(bus_valid), 32'd0);
            end
            if (c == 7) begin
                chk("burst2_bv",   32'(bus_valid),   32'd1);
                chk("burst2_data", 32'(bus_data),    32'h05);
                chk("burst2_td",   32'(tenure_done), 32'd0);
            end
            if (c == 8) begin
                chk("burst2_last", 32'(bus_data),    32'h06);
                chk("burst2_ltd",  32'(tenure_done), 32'd1);
            end
            adv();
        end
        drain();

        // Grant preemption in the middle of a tenure
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 4);
            in_data  = 8'(8'h11 + c);
            grant    = ((c >= 4) && (c <= 5)) || (c >= 9);
            mid();
            if (c == 7) begin
                chk("preempt_req", 32'(request),   32'd1);
                chk("preempt_bv",  32'(bus_valid), 32'd0);
            end
            if (c == 9) begin
                chk("preempt_b3", 32'(bus_data),    32'h13);
                chk("preempt_t3", 32'(tenure_done), 32'd0);
            end
            if (c == 10) begin
                chk("preempt_b4", 32'(bus_data),    32'h14);
                chk("preempt_t4", 32'(tenure_done), 32'd1);
            end
            if (c == 11) chk("preempt_drop", 32'(request), 32'd0);
            adv();
        end

        // Full FIFO with in_valid held, then release grant
        word = 8'h21;
        for (int c = 0; c < 13; c++) begin
            grant    = (c >= 6);
            in_valid = (word <= 8'h25);
            in_data  = word;
            mid();
            if (c == 4) chk("full_ready", 32'(in_ready), 32'd0);
            if (c == 6) begin
                chk("full_pop_data",  32'(bus_data), 32'h21);
                chk("full_pop_ready", 32'(in_ready), 32'd0);
            end
            if (c == 7) begin
                chk("full_reopen", 32'(in_ready), 32'd1);
                chk("full_order",  32'(bus_data), 32'h22);
            end
            if (c == 11) begin
                chk("full_tail",    32'(bus_data),    32'h25);
                chk("full_tail_td", 32'(tenure_done), 32'd1);
            end
            if (in_valid && in_ready) word = word + 8'd1;
            adv();
        end

        // Push and pop in the same cycle with one word held
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 0) || (c == 2);
            in_data  = (c == 0) ? 8'h31 : 8'h32;
            grant    = 1'b1;
            mid();
            if (c == 2) begin
                chk("pp_data", 32'(bus_data),    32'h31);
                chk("pp_td",   32'(tenure_done), 32'd0);
            end
            if (c == 3) begin
                chk("pp_next", 32'(bus_data),    32'h32);
                chk("pp_ntd",  32'(tenure_done), 32'd1);
            end
            adv();
        end
        drain();

        // Asynchronous reset mid-tenure with three words queued
        for (int c = 0; c < 4; c++) begin
            in_valid = (c < 3);
            in_data  = 8'(8'h41 + c);
            grant    = 1'b0;
            if (c < 3) adv();
        end
        mid();
        chk("pre_rst_request", 32'(request), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_request",  32'(request),  32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        grant    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        adv();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk("post_rst_bv",  32'(bus_valid), 32'd0);
            chk("post_rst_req", 32'(request),   32'd0);
            adv();
        end

        // Randomized traffic with varying grant and push densities
        for (int c = 0; c < 4000; c++) begin
            int g_pct;
            int v_pct;
            g_pct    = (c < 2000) ? 75 : 25;
            v_pct    = (c < 1000 || c >= 3000) ? 50 : 80;
            in_valid = ($urandom_range(0, 99) < v_pct);
            in_data  = DW'($urandom);
            grant    = ($urandom_range(0, 99) < g_pct);
            adv();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
